// File: rtl/dcache_pkg.sv
// dcache_pkg: shared encodings and address field layout for the data-cache controller
package dcache_pkg;
  localparam int ADDR_W = 32;
  localparam int TAG_W = 23;
  localparam int IDX_W = 4;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int OFF_W = 3;
  localparam int TAG_LSB = 9;
  localparam int IDX_LSB = 5;
  localparam int OFF_LSB = 2;
  localparam int VALID = 24;
  localparam int DIRTY = 23;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one word of a line for loads and replaces it for stores
//   line_i  cache line      off_i  word offset      word_i  store word
//   word_o  selected word   line_o line with word off_i replaced by word_i
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);
  always_comb begin
    word_o = line_i[{off_i, 5'b0} +: WORD_W];
    line_o = line_i;
    line_o[{off_i, 5'b0} +: WORD_W] = word_i;
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: write-back/write-allocate sequencer between CPU, cache SRAM and memory
//   clk_i/rst_i                     clock, async active-high reset
//   cpu_req/write/addr/data_i       CPU access, held while cpu_stall_o
//   cpu_data_o/cpu_stall_o          load data, pipeline stall
//   sram_addr/tag/data/enable/write_o, sram_tag/data/hit_i   cache SRAM port
//   mem_enable/write/addr/data_o, mem_data_i/mem_ack_i        main-memory line port
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_write_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [WORD_W-1:0]   cpu_data_i,
  output logic [WORD_W-1:0]   cpu_data_o,
  output logic                cpu_stall_o,
  output logic [IDX_W-1:0]    sram_addr_o,
  output logic [TAG_W+1:0]    sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  input  logic [TAG_W+1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);
  state_e state_q, state_d;
  logic [ADDR_W-1:IDX_LSB] addr_q, addr_d;
  logic [TAG_W-1:0] victim_q, victim_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] rd_word;
  logic [LINE_W-1:0] wr_line;
  logic req, wr_hit;
  // Reset also masks the request so every output is low while rst_i is held.
  assign req = cpu_req_i & ~rst_i;
  assign wr_hit = cpu_write_i & sram_hit_i;
  dcache_word_merge u_merge (
    .line_i (sram_data_i),
    .off_i  (cpu_addr_i[IDX_LSB-1:OFF_LSB]),
    .word_i (cpu_data_i),
    .word_o (rd_word),
    .line_o (wr_line)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      victim_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      victim_q <= victim_d;
      line_q <= line_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    victim_d = victim_q;
    line_d = line_q;
    cpu_data_o = '0;
    cpu_stall_o = 1'b0;
    sram_addr_o = '0;
    sram_tag_o = '0;
    sram_data_o = '0;
    sram_enable_o = 1'b0;
    sram_write_o = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state_q)
      IDLE: if (req) begin
        sram_enable_o = 1'b1;
        sram_addr_o = cpu_addr_i[TAG_LSB-1:IDX_LSB];
        sram_tag_o = {1'b1, wr_hit, cpu_addr_i[ADDR_W-1:TAG_LSB]};
        sram_write_o = wr_hit;
        sram_data_o = wr_hit ? wr_line : '0;
        cpu_data_o = (sram_hit_i & ~cpu_write_i) ? rd_word : '0;
        cpu_stall_o = ~sram_hit_i;
        if (!sram_hit_i) begin
          addr_d = cpu_addr_i[ADDR_W-1:IDX_LSB];
          victim_d = sram_tag_i[TAG_W-1:0];
          line_d = sram_data_i;
          state_d = (sram_tag_i[VALID] & sram_tag_i[DIRTY]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        sram_addr_o = addr_q[TAG_LSB-1:IDX_LSB];
        mem_enable_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o = {victim_q, addr_q[TAG_LSB-1:IDX_LSB], 5'b0};
        mem_data_o = line_q;
        state_d = mem_ack_i ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        sram_addr_o = addr_q[TAG_LSB-1:IDX_LSB];
        mem_enable_o = 1'b1;
        mem_addr_o = {addr_q, 5'b0};
        line_d = mem_ack_i ? mem_data_i : line_q;
        state_d = mem_ack_i ? REFILL : ALLOCATE;
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        sram_enable_o = 1'b1;
        sram_write_o = 1'b1;
        sram_addr_o = addr_q[TAG_LSB-1:IDX_LSB];
        sram_tag_o = {2'b10, addr_q[ADDR_W-1:TAG_LSB]};
        sram_data_o = line_q;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized and directed checks against a flat-memory / LRU-set reference
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_write;
  logic [31:0] cpu_addr, cpu_data;
  logic [31:0] cpu_data_o;
  logic cpu_stall_o;
  logic [3:0] sram_addr_o;
  logic [24:0] sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic sram_enable_o, sram_write_o, sram_hit_i;
  logic mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0] mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  int nchk = 0, nerr = 0;

  // SRAM environment: 2 ways, 16 sets, LRU victim selection
  logic [24:0] s_tag [16][2];
  logic [255:0] s_data [16][2];
  logic s_lru [16];
  logic lk_way;

  // Memory environment
  logic [255:0] mem_line [logic [26:0]];
  int lat, cnt;
  logic [31:0] wb_addr_q[$];
  logic [255:0] wb_data_q[$];
  logic [31:0] alloc_q[$];

  // Reference: flat word view plus per-set MRU-ordered tag lists
  logic [31:0] ref_w [logic [29:0]];
  logic [22:0] rc_tag [16][2];
  logic rc_dirty [16][2];
  int rc_n [16];

  logic stall_s, men_s, mwr_s;
  logic [31:0] data_s;
  int last_stalls;

  function automatic logic [255:0] pattern(input logic [26:0] la);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) begin
      logic [2:0] w3;
      w3 = w[2:0];
      r[w*32 +: 32] = {la[23:0], 5'b10101, w3};
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [255:0] p;
    if (ref_w.exists(a[31:2])) return ref_w[a[31:2]];
    p = pattern(a[31:5]);
    return p[{a[4:2], 5'b0} +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [26:0] la);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) begin
      logic [2:0] w3;
      w3 = w[2:0];
      r[w*32 +: 32] = ref_word({la, w3, 2'b00});
    end
    return r;
  endfunction

  function automatic logic [255:0] line_of(input logic [26:0] la);
    return mem_line.exists(la) ? mem_line[la] : pattern(la);
  endfunction

  function automatic int find_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (s_tag[a[8:5]][w][24] && s_tag[a[8:5]][w][22:0] == a[31:9]) return w;
    return -1;
  endfunction

  function automatic void lookup();
    logic [3:0] i;
    logic h0, h1;
    i = cpu_addr[8:5];
    h0 = s_tag[i][0][24] && s_tag[i][0][22:0] == cpu_addr[31:9];
    h1 = s_tag[i][1][24] && s_tag[i][1][22:0] == cpu_addr[31:9];
    lk_way = h0 ? 1'b0 : h1 ? 1'b1 : s_lru[i];
    sram_hit_i = h0 | h1;
    sram_tag_i = s_tag[i][lk_way];
    sram_data_i = s_data[i][lk_way];
  endfunction

  // One clock: sample at negedge, update environment 1 time unit after posedge.
  task automatic cycle();
    logic se, sw, rh, rw, nack, way;
    logic [3:0] si;
    logic [24:0] st;
    logic [255:0] sd;
    logic [31:0] aa;
    @(negedge clk);
    stall_s = cpu_stall_o;
    data_s = cpu_data_o;
    men_s = mem_enable_o;
    mwr_s = mem_write_o;
    se = sram_enable_o; sw = sram_write_o; si = sram_addr_o; st = sram_tag_o; sd = sram_data_o;
    rh = sram_hit_i; rw = lk_way;
    aa = mem_addr_o;
    nack = 1'b0;
    if (mem_enable_o && mem_ack_i) begin
      if (mem_write_o) begin
        mem_line[mem_addr_o[31:5]] = mem_data_o;
        wb_addr_q.push_back(mem_addr_o);
        wb_data_q.push_back(mem_data_o);
      end else alloc_q.push_back(mem_addr_o);
      cnt = 0;
    end else if (mem_enable_o) begin
      cnt++;
      nack = (cnt == lat);
    end
    @(posedge clk);
    #1;
    if (se && sw) begin
      way = (s_tag[si][0][24] && s_tag[si][0][22:0] == st[22:0]) ? 1'b0 :
            (s_tag[si][1][24] && s_tag[si][1][22:0] == st[22:0]) ? 1'b1 : s_lru[si];
      s_tag[si][way] = st;
      s_data[si][way] = sd;
      s_lru[si] = ~way;
    end else if (se && rh) s_lru[si] = ~rw;
    mem_ack_i = nack;
    mem_data_i = nack ? line_of(aa[31:5]) : '0;
    lookup();
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input int l);
    int pos, exp_stall, n;
    logic [3:0] s;
    logic [22:0] t, tt;
    logic dd, exp_wb;
    logic [31:0] wb_a, exp_d;
    logic [255:0] wb_d;
    s = a[8:5];
    t = a[31:9];
    pos = -1;
    for (int i = 0; i < rc_n[s]; i++) if (rc_tag[s][i] == t) pos = i;
    exp_wb = 1'b0;
    wb_a = '0;
    wb_d = '0;
    if (pos >= 0) exp_stall = 0;
    else begin
      exp_wb = (rc_n[s] == 2) && rc_dirty[s][1];
      if (exp_wb) begin
        wb_a = {rc_tag[s][1], s, 5'b0};
        wb_d = ref_line(wb_a[31:5]);
      end
      exp_stall = 2 + (l + 1) + (exp_wb ? l + 1 : 0);
    end
    if (pos == 1) begin
      tt = rc_tag[s][1]; dd = rc_dirty[s][1];
      rc_tag[s][1] = rc_tag[s][0]; rc_dirty[s][1] = rc_dirty[s][0];
      rc_tag[s][0] = tt; rc_dirty[s][0] = dd;
    end else if (pos < 0) begin
      rc_tag[s][1] = rc_tag[s][0]; rc_dirty[s][1] = rc_dirty[s][0];
      rc_tag[s][0] = t; rc_dirty[s][0] = 1'b0;
      if (rc_n[s] < 2) rc_n[s]++;
    end
    if (wr) rc_dirty[s][0] = 1'b1;
    exp_d = ref_word(a);
    wb_addr_q.delete(); wb_data_q.delete(); alloc_q.delete();
    lat = l;
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_data = d;
    lookup();
    last_stalls = 0;
    n = 0;
    cycle();
    while (stall_s && n < 200) begin
      last_stalls++; n++;
      cycle();
    end
    nchk++;
    if (stall_s !== 1'b0) begin
      nerr++;
      $display("FAIL timeout addr=%h: still stalled after %0d cycles, required release", a, n);
    end
    nchk++;
    if (last_stalls != exp_stall) begin
      nerr++;
      $display("FAIL stall_count addr=%h: got %0d expected %0d", a, last_stalls, exp_stall);
    end
    if (!wr) begin
      nchk++;
      if (data_s !== exp_d) begin
        nerr++;
        $display("FAIL load_data addr=%h: got %h expected %h", a, data_s, exp_d);
      end
    end
    nchk++;
    if (wb_addr_q.size() != (exp_wb ? 1 : 0)) begin
      nerr++;
      $display("FAIL wb_count addr=%h: got %0d expected %0d", a, wb_addr_q.size(), exp_wb);
    end else if (exp_wb) begin
      nchk++;
      if (wb_addr_q[0] !== wb_a || wb_data_q[0] !== wb_d) begin
        nerr++;
        $display("FAIL wb_line addr=%h: got %h/%h expected %h/%h", a, wb_addr_q[0], wb_data_q[0], wb_a, wb_d);
      end
    end
    if (pos < 0) begin
      nchk++;
      if (alloc_q.size() != 1 || alloc_q[0] !== {a[31:5], 5'b0}) begin
        nerr++;
        $display("FAIL alloc_addr addr=%h: got %0d reqs first %h expected 1 req %h", a, alloc_q.size(),
                 alloc_q.size() > 0 ? alloc_q[0] : 32'h0, {a[31:5], 5'b0});
      end
    end
    if (wr) ref_w[a[31:2]] = d;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    cpu_write = 1'b0;
    lookup();
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40; cpu_data = '0;
    lookup();
    repeat (2) @(negedge clk);
    nchk++;
    if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || sram_enable_o !== 1'b0 || sram_write_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: stall=%b mem_en=%b sram_en=%b sram_wr=%b expected all 0",
               cpu_stall_o, mem_enable_o, sram_enable_o, sram_write_o);
    end
    nchk++;
    if (sram_tag_o !== '0 || mem_addr_o !== '0 || cpu_data_o !== '0 || sram_addr_o !== '0) begin
      nerr++;
      $display("FAIL reset_data: tag=%h maddr=%h data=%h saddr=%h expected 0", sram_tag_o, mem_addr_o, cpu_data_o, sram_addr_o);
    end
    cpu_req = 1'b0;
    lookup();
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    nchk++;
    if (stall_s !== 1'b0 || men_s !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset_idle: stall=%b mem_en=%b expected 0 0", stall_s, men_s);
    end
  endtask

  task automatic test_cold_load();
    int w;
    access(1'b0, 32'h40, 32'h0, 5);
    nchk++;
    if (last_stalls != 8) begin
      nerr++;
      $display("FAIL cold_load_stall: got %0d expected 8", last_stalls);
    end
    w = find_way(32'h40);
    nchk++;
    if (w < 0 || s_tag[2][w < 0 ? 0 : w] !== 25'h1000000) begin
      nerr++;
      $display("FAIL cold_load_tag: way=%0d tag=%h expected 1000000", w, s_tag[2][w < 0 ? 0 : w]);
    end
  endtask

  task automatic test_store_hit();
    int w;
    access(1'b1, 32'h44, 32'hDEADBEEF, 3);
    w = find_way(32'h44);
    nchk++;
    if (w < 0 || s_tag[2][w < 0 ? 0 : w] !== 25'h1800000 || s_data[2][w < 0 ? 0 : w][63:32] !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL store_hit_line: way=%0d tag=%h word1=%h expected 1800000 deadbeef",
               w, s_tag[2][w < 0 ? 0 : w], s_data[2][w < 0 ? 0 : w][63:32]);
    end
  endtask

  task automatic test_evict();
    access(1'b0, 32'h240, 32'h0, 2);
    access(1'b0, 32'h440, 32'h0, 2);
    nchk++;
    if (wb_addr_q.size() != 1 || wb_addr_q[0] !== 32'h40 || wb_data_q[0][63:32] !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL evict_dirty: wbs=%0d addr=%h word1=%h expected 1 00000040 deadbeef", wb_addr_q.size(),
               wb_addr_q.size() > 0 ? wb_addr_q[0] : 32'h0, wb_data_q.size() > 0 ? wb_data_q[0][63:32] : 32'h0);
    end
    nchk++;
    if (alloc_q.size() != 1 || alloc_q[0] !== 32'h440) begin
      nerr++;
      $display("FAIL evict_alloc: got %h expected 00000440", alloc_q.size() > 0 ? alloc_q[0] : 32'h0);
    end
  endtask

  task automatic test_store_miss();
    int w;
    logic [31:0] d;
    d = $urandom;
    access(1'b1, 32'h1000, d, 4);
    w = find_way(32'h1000);
    nchk++;
    if (w < 0 || s_tag[0][w < 0 ? 0 : w] !== {2'b11, 23'd8} || s_data[0][w < 0 ? 0 : w][31:0] !== d) begin
      nerr++;
      $display("FAIL store_miss_line: way=%0d tag=%h word0=%h expected %h %h",
               w, s_tag[0][w < 0 ? 0 : w], s_data[0][w < 0 ? 0 : w][31:0], {2'b11, 23'd8}, d);
    end
    access(1'b0, 32'h1000, 32'h0, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 6;
    cnt = 0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h2000_0060; cpu_data = '0;
    lookup();
    n = 0;
    cycle();
    while (!(men_s && !mwr_s) && n < 20) begin
      n++;
      cycle();
    end
    nchk++;
    if (!(men_s && !mwr_s)) begin
      nerr++;
      $display("FAIL reset_mid_alloc: mem_en=%b mem_wr=%b expected 1 0", men_s, mwr_s);
    end
    #2;
    rst = 1'b1;
    #1;
    nchk++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_drop: mem_en=%b stall=%b expected 0 0", mem_enable_o, cpu_stall_o);
    end
    cpu_req = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    cnt = 0;
    lookup();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    access(1'b0, 32'h2000_0060, 32'h0, 3);
  endtask

  task automatic test_back_to_back();
    int total;
    logic [31:0] a;
    access(1'b0, 32'h0A0, 32'h0, 2);
    access(1'b0, 32'h2A0, 32'h0, 2);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 32'h0A0 : 32'h2A0;
      a[4:2] = 3'($urandom_range(0, 7));
      access(1'b0, a, 32'h0, 1);
      total += last_stalls;
    end
    nchk++;
    if (total != 0) begin
      nerr++;
      $display("FAIL back_to_back_stalls: got %0d expected 0", total);
    end
    idle(1);
    mem_ack_i = 1'b1;
    mem_data_i = {8{32'hBAD0BAD0}};
    cycle();
    nchk++;
    if (stall_s !== 1'b0 || men_s !== 1'b0) begin
      nerr++;
      $display("FAIL stray_ack_idle: stall=%b mem_en=%b expected 0 0", stall_s, men_s);
    end
    access(1'b0, 32'h2A4, 32'h0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [22:0] t;
    for (int i = 0; i < 80; i++) begin
      t = 23'h1234 + 23'($urandom_range(0, 3));
      a = {t, 4'($urandom_range(6, 7)), 3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    lat = 1; cnt = 0;
    for (int s = 0; s < 16; s++) begin
      s_lru[s] = 1'b0;
      rc_n[s] = 0;
      for (int w = 0; w < 2; w++) begin
        s_tag[s][w] = '0;
        s_data[s][w] = '0;
        rc_tag[s][w] = '0;
        rc_dirty[s][w] = 1'b0;
      end
    end
    lookup();
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_store_miss();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
